// File: rtl/lfsr32_pkg.sv
// lfsr32_pkg
// Shared definitions for the 32-bit Galois LFSR generator and checker:
// the seed constant, the polynomial step function, and the checker FSM
// state encoding.
package lfsr32_pkg;

  localparam logic [31:0] LFSR32_SEED = 32'h1;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  // One step of the Galois LFSR: shift right, with bit 0 fed back into
  // bit 31 and XORed into taps 21, 1 and 0.
  function automatic logic [31:0] lfsr32_next(input logic [31:0] x);
    logic [31:0] n;
    n     = {x[0], x[31:1]};
    n[21] = x[22] ^ x[0];
    n[1]  = x[2] ^ x[0];
    n[0]  = x[1] ^ x[0];
    return n;
  endfunction

endpackage

// File: rtl/lfsr32_checker.sv
// lfsr32_checker
// Samples the LFSR generator word stream, self-synchronises to it in HUNT,
// then flywheels its own copy of the sequence in LOCKED and counts words
// that disagree.
//
// Ports:
//   clk       sole clock, rising edge
//   reset_n   asynchronous active-low reset
//   in_valid  in_data carries a new generator word this cycle
//   in_data   generator word
//   clear     synchronous clear of err_cnt (wins over an increment)
//   locked    checker synchronised to the stream
//   err       one-cycle pulse per mismatching word while LOCKED
//   err_cnt   saturating count of mismatching words
//   zero_det  one-cycle pulse when an all-zero word is sampled
//
// state  | meaning
// HUNT   | seeding from the stream, counting consecutive matches
// LOCKED | flywheeling expected sequence, counting mismatches
module lfsr32_checker
  import lfsr32_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             zero_det
);

  localparam int HW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(UNLOCK_CNT + 1);

  chk_state_t       state_q, state_d;
  logic [31:0]      exp_q, exp_d;
  logic             seeded_q, seeded_d;
  logic [HW-1:0]    hunt_q, hunt_d, hunt_inc;
  logic [MW-1:0]    miss_q, miss_d, miss_inc;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_q, err_d;
  logic             zero_q, zero_d;
  logic [31:0]      next_of_data, next_of_exp;

  always_comb begin
    state_d      = state_q;
    exp_d        = exp_q;
    seeded_d     = seeded_q;
    hunt_d       = hunt_q;
    miss_d       = miss_q;
    err_cnt_d    = err_cnt_q;
    err_d        = 1'b0;
    zero_d       = 1'b0;
    next_of_data = lfsr32_next(in_data);
    next_of_exp  = lfsr32_next(exp_q);
    hunt_inc     = hunt_q + 1'b1;
    miss_inc     = miss_q + 1'b1;

    case (state_q)
      HUNT: begin
        if (in_valid) begin
          if (in_data == 32'h0) begin
            zero_d   = 1'b1;
            seeded_d = 1'b0;
            hunt_d   = '0;
          end else if (!seeded_q) begin
            exp_d    = next_of_data;
            seeded_d = 1'b1;
          end else if (in_data == exp_q) begin
            exp_d  = next_of_data;
            hunt_d = hunt_inc;
            if (hunt_inc == HW'(LOCK_CNT)) begin
              state_d = LOCKED;
              miss_d  = '0;
              hunt_d  = '0;
            end
          end else begin
            exp_d  = next_of_data;
            hunt_d = '0;
          end
        end
      end
      LOCKED: begin
        if (in_valid) begin
          // Flywheel: the expected word advances whether or not it matched.
          exp_d  = next_of_exp;
          zero_d = (in_data == 32'h0);
          if (in_data == exp_q) begin
            miss_d = '0;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            miss_d = miss_inc;
            if (miss_inc == MW'(UNLOCK_CNT)) begin
              state_d  = HUNT;
              seeded_d = 1'b0;
              hunt_d   = '0;
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase

    if (clear) err_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= HUNT;
      exp_q     <= '0;
      seeded_q  <= 1'b0;
      hunt_q    <= '0;
      miss_q    <= '0;
      err_cnt_q <= '0;
      err_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      seeded_q  <= seeded_d;
      hunt_q    <= hunt_d;
      miss_q    <= miss_d;
      err_cnt_q <= err_cnt_d;
      err_q     <= err_d;
      zero_q    <= zero_d;
    end
  end

  assign locked   = (state_q == LOCKED);
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;
  assign zero_det = zero_q;

endmodule
